// File: rtl/random_range_sampler.sv
// random_range_sampler
// Bounded random index generator that sits directly downstream of a 32-bit
// LFSR generator. Each request runs one or more gen/gen_end handshakes with
// the generator and maps the returned word into [0, range-1]. The word is
// masked down to the smallest power-of-two window that covers the range, and
// out-of-range candidates are rejected and redrawn. In unique mode a
// draw-history bitmap ensures that each value is issued at most once until
// the history is cleared.
module random_range_sampler #(
  parameter int W         = 4,
  parameter int MAX_TRIES = 8,
  parameter int WAIT_MAX  = 15
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         req,
  input  logic [W:0]   range,
  input  logic         unique_mode,
  input  logic         clear_hist,
  output logic         prng_gen,
  input  logic [31:0]  prng_q,
  input  logic         prng_gen_end,
  output logic         busy,
  output logic         valid,
  output logic [W-1:0] value,
  output logic         fail
);

  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [TW-1:0] TRIES_LAST = TW'(MAX_TRIES - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(WAIT_MAX - 1);
  // Largest legal range value: 2^W.
  localparam logic [W:0]    M_MAX      = {1'b1, {W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CHECK
  } state_t;

  state_t          state_reg;
  logic [W:0]      range_reg;
  logic            uniq_reg;
  logic [TW-1:0]   tries_reg;
  logic [WW-1:0]   wait_cnt_reg;
  logic [W-1:0]    cand_reg;
  logic [W-1:0]    value_reg;
  logic            valid_reg;
  logic            fail_reg;
  logic [2**W-1:0] used_reg;
  logic [W:0]      used_count_reg;

  logic [W-1:0]    m_minus1;
  logic [W-1:0]    mask;
  logic            range_bad;
  logic            hist_full;
  logic            cand_ok;
  // The generator word is wider than any legal result; only the low W bits
  // can survive masking, so the upper bits are intentionally discarded.
  logic            unused_q_bits;

  assign unused_q_bits = ^prng_q[31:W];

  // Mask = 2^ceil(log2 M) - 1, obtained by smearing the highest set bit of
  // (M-1) downward. M=1 gives 0; M=2^W wraps M-1 to all ones.
  assign m_minus1 = range_reg[W-1:0] - W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_mask
      assign mask[gi] = |m_minus1[W-1:gi];
    end
  endgenerate

  // Request screening, done on the live inputs while IDLE.
  assign range_bad = (range == '0) || (range > M_MAX);
  assign hist_full = unique_mode && (used_count_reg >= range);

  // The history bitmap is consulted only for unique-mode requests.
  assign cand_ok = ({1'b0, cand_reg} < range_reg) &&
                   (!uniq_reg || !used_reg[cand_reg]);

  // Control FSM with registered result pulses. The history clear is applied
  // last, so it overrides a history update made in the same cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg      <= S_IDLE;
      range_reg      <= '0;
      uniq_reg       <= 1'b0;
      tries_reg      <= '0;
      wait_cnt_reg   <= '0;
      cand_reg       <= '0;
      value_reg      <= '0;
      valid_reg      <= 1'b0;
      fail_reg       <= 1'b0;
      used_reg       <= '0;
      used_count_reg <= '0;
    end else begin
      valid_reg <= 1'b0;
      fail_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (req) begin
            if (range_bad || hist_full) begin
              fail_reg <= 1'b1;
            end else begin
              range_reg <= range;
              uniq_reg  <= unique_mode;
              tries_reg <= '0;
              state_reg <= S_REQ;
            end
          end
        end
        S_REQ: begin
          wait_cnt_reg <= '0;
          state_reg    <= S_WAIT;
        end
        S_WAIT: begin
          if (prng_gen_end) begin
            // q is already updated in the gen_end cycle.
            cand_reg  <= prng_q[W-1:0] & mask;
            state_reg <= S_CHECK;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            fail_reg  <= 1'b1;
            state_reg <= S_IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WW'(1);
          end
        end
        S_CHECK: begin
          if (cand_ok) begin
            value_reg <= cand_reg;
            valid_reg <= 1'b1;
            if (uniq_reg) begin
              used_reg[cand_reg] <= 1'b1;
              if (used_count_reg != M_MAX) begin
                used_count_reg <= used_count_reg + (W+1)'(1);
              end
            end
            state_reg <= S_IDLE;
          end else begin
            tries_reg <= tries_reg + TW'(1);
            if (tries_reg == TRIES_LAST) begin
              fail_reg  <= 1'b1;
              state_reg <= S_IDLE;
            end else begin
              state_reg <= S_REQ;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
      if (clear_hist) begin
        used_reg       <= '0;
        used_count_reg <= '0;
      end
    end
  end

  assign prng_gen = (state_reg == S_REQ);
  assign busy     = (state_reg != S_IDLE);
  assign valid    = valid_reg;
  assign fail     = fail_reg;
  assign value    = value_reg;

endmodule
